timer_mod: RTL and testbench

- Memory-mapped 32-bit timer/compare peripheral on the CPU data bus, selected at module address 4'h5 (dbus_adr[31:28]).
- Its level interrupt output drives the interrupt controller's int3 input, which is currently tied to 0.
- Gives the SoC a periodic or one-shot tick source for scheduling and delays.

---
 rtl/timer_mod_pkg.sv | 27 ++
 rtl/timer_mod_prescaler.sv | 39 +++
 rtl/timer_mod.sv | 115 +++++++++++
 tb/tb_timer_mod.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_mod_pkg.sv
// Shared register map, CTRL bit layout and module-select constant for the
// memory-mapped timer/compare peripheral.
package timer_mod_pkg;

  typedef enum logic [1:0] {
    TMR_CTRL = 2'd0,
    TMR_PRE  = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_CMP  = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_PEND = 3;

  localparam logic [3:0] TIMER_ADDR = 4'h5;

  // Packed so that the struct image is exactly the CTRL read value {PEND,MODE,IE,EN}.
  typedef struct packed {
    logic pend;
    logic mode;
    logic ie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_mod_prescaler.sv
// Prescale divider: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module timer_mod_prescaler
  import timer_mod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_o = en_i && (pre_cnt_q == prescale_i);

  // A clear restarts the phase even when it lands on a tick cycle.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr_i) begin
      pre_cnt_d = '0;
    end else if (tick_o) begin
      pre_cnt_d = '0;
    end else if (en_i) begin
      pre_cnt_d = pre_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/timer_mod.sv
// Timer/compare peripheral: bus register file, compare counter and level
// interrupt; the prescale divider lives in timer_mod_prescaler.
module timer_mod
  import timer_mod_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] PRE_RESET = '0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  addr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        int_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;
  logic [31:0]      rd_data;

  logic access, wr, wr_ctrl, wr_pre, wr_cnt, wr_cmp;
  logic tick, match, pre_clr;

  assign access  = i_wb_cyc && !ack_q;
  assign wr      = access && i_wb_we;
  assign wr_ctrl = wr && (addr == TMR_CTRL);
  assign wr_pre  = wr && (addr == TMR_PRE);
  assign wr_cnt  = wr && (addr == TMR_CNT);
  assign wr_cmp  = wr && (addr == TMR_CMP);

  // A COUNT write on a tick cycle suppresses the compare entirely.
  assign match   = tick && !wr_cnt && (cnt_q == cmp_q);
  assign pre_clr = wr_pre || wr_cnt || (wr_ctrl && i_wb_dat[CTRL_EN] && !ctrl_q.en);

  timer_mod_prescaler #(
    .WIDTH(WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .rstn      (rstn),
    .en_i      (ctrl_q.en),
    .clr_i     (pre_clr),
    .prescale_i(pre_q),
    .tick_o    (tick)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      TMR_CTRL: rd_data = {28'd0, ctrl_q};
      TMR_PRE:  rd_data = 32'(pre_q);
      TMR_CNT:  rd_data = 32'(cnt_q);
      TMR_CMP:  rd_data = 32'(cmp_q);
      default:  rd_data = '0;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    ack_d  = i_wb_cyc && !ack_q;
    rdt_d  = access ? rd_data : rdt_q;

    if (tick && !wr_cnt) begin
      cnt_d = (cnt_q == cmp_q) ? '0 : cnt_q + WIDTH'(1);
    end
    if (match) begin
      ctrl_d.pend = 1'b1;
      if (ctrl_q.mode) ctrl_d.en = 1'b0;
    end

    // Bus writes come last so a written EN beats the one-shot auto-clear,
    // while a match still beats the PEND write-1-to-clear.
    if (wr_ctrl) begin
      ctrl_d.en   = i_wb_dat[CTRL_EN];
      ctrl_d.ie   = i_wb_dat[CTRL_IE];
      ctrl_d.mode = i_wb_dat[CTRL_MODE];
      if (i_wb_dat[CTRL_PEND] && !match) ctrl_d.pend = 1'b0;
    end
    if (wr_pre) pre_d = WIDTH'(i_wb_dat);
    if (wr_cnt) cnt_d = WIDTH'(i_wb_dat);
    if (wr_cmp) cmp_d = WIDTH'(i_wb_dat);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q <= '0;
      pre_q  <= PRE_RESET;
      cnt_q  <= '0;
      cmp_q  <= '1;
      ack_q  <= 1'b0;
      rdt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      ack_q  <= ack_d;
      rdt_q  <= rdt_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign int_o    = ctrl_q.pend && ctrl_q.ie;

endmodule

// File: tb/tb_timer_mod.sv
// Directed and randomized bench for timer_mod against a cycle-level
// behavioural model (tick = enabled-cycle phase modulo PRESCALE+1).
module tb_timer_mod;
  import timer_mod_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] i_wb_dat = 32'd0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        int_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  timer_mod #(
    .WIDTH    (32),
    .PRE_RESET(32'd0)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .addr    (addr),
    .i_wb_dat(i_wb_dat),
    .i_wb_we (i_wb_we),
    .i_wb_cyc(i_wb_cyc),
    .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack),
    .int_o   (int_o)
  );

  // ---------------- behavioural model ----------------
  bit              m_en, m_ie, m_mode, m_pend, m_ack;
  logic [31:0]     m_pre, m_cnt, m_cmp, m_rdt;
  longint unsigned m_phase;

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_mode = 0; m_pend = 0; m_ack = 0;
    m_pre = 32'd0; m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_rdt = 32'd0;
    m_phase = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_pend, m_mode, m_ie, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return m_cmp;
    endcase
  endfunction

  task automatic model_edge(input bit cyc, input bit we, input logic [1:0] a, input logic [31:0] d);
    bit acc, wr, tick, hit, en_old;
    acc    = cyc && !m_ack;
    wr     = acc && we;
    en_old = m_en;
    hit    = 0;
    tick   = m_en && ((m_phase % (64'(m_pre) + 64'd1)) == 64'(m_pre));
    if (acc) m_rdt = m_read(a);
    if (m_en) m_phase++;
    if (tick && !(wr && a == 2'd2)) begin
      if (m_cnt == m_cmp) begin
        hit = 1; m_pend = 1; m_cnt = 32'd0;
        if (m_mode) m_en = 0;
      end else begin
        m_cnt = m_cnt + 32'd1;
      end
    end
    if (wr) begin
      case (a)
        2'd0: begin
          m_en = d[0]; m_ie = d[1]; m_mode = d[2];
          if (d[3] && !hit) m_pend = 0;
          if (d[0] && !en_old) m_phase = 0;
        end
        2'd1: begin m_pre = d; m_phase = 0; end
        2'd2: begin m_cnt = d; m_phase = 0; end
        default: m_cmp = d;
      endcase
    end
    m_ack = acc;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit cyc, input bit we, input logic [1:0] a, input logic [31:0] d);
    i_wb_cyc = cyc; i_wb_we = we; addr = a; i_wb_dat = d;
    @(posedge clk);
    model_edge(cyc, we, a, d);
    #1;
    chk("ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
    chk("rdt", o_wb_rdt, m_rdt);
    chk("int", {31'd0, int_o}, {31'd0, m_pend & m_ie});
  endtask

  task automatic access(input bit we, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
    step(1, we, a, d);
    rd = o_wb_rdt;
    step(0, 0, a, 32'd0);
  endtask

  // n counts edges since the write edge that started the timer; -1 on timeout.
  task automatic wait_int(input int start, output int n);
    n = start;
    while (!int_o && n < 64) begin
      step(0, 0, 2'd0, 32'd0);
      n++;
    end
    if (!int_o) n = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n;
    logic [1:0] ra;
    bit rwe;
    logic [31:0] rdat;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_int", {31'd0, int_o}, 32'd0);
    access(0, TMR_CMP, 0, rd); chk("rst_cmp", rd, 32'hFFFF_FFFF);

    // Periodic: PRESCALE=1, COMPARE=4 -> period 10
    access(1, TMR_PRE, 32'd1, rd);
    access(1, TMR_CMP, 32'd4, rd);
    access(1, TMR_CNT, 32'd0, rd);
    access(1, TMR_CTRL, 32'h3, rd);
    wait_int(1, n); chk("per_first", 32'(n), 32'd10);
    access(1, TMR_CTRL, 32'hB, rd);
    chk("per_w1c_int", {31'd0, int_o}, 32'd0);
    wait_int(2, n); chk("per_period", 32'(n), 32'd10);

    // Reset mid-transaction
    step(1, 0, TMR_CTRL, 32'd0);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("mid_rst_rdt", o_wb_rdt, 32'd0);
    chk("mid_rst_int", {31'd0, int_o}, 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    step(1, 0, TMR_CTRL, 32'd0);
    chk("fresh_ack", {31'd0, o_wb_ack}, 32'd1);
    step(0, 0, TMR_CTRL, 32'd0);
    access(0, TMR_CTRL, 0, rd); chk("rst_ctrl", rd, 32'd0);
    access(0, TMR_CNT, 0, rd);  chk("rst_cnt", rd, 32'd0);
    access(0, TMR_CMP, 0, rd);  chk("rst_cmp2", rd, 32'hFFFF_FFFF);
    access(0, TMR_PRE, 0, rd);  chk("rst_pre", rd, 32'd0);

    // One-shot: PRESCALE=0, COMPARE=2 -> 3 ticks, then EN auto-clears
    access(1, TMR_CMP, 32'd2, rd);
    access(1, TMR_CTRL, 32'hF, rd);
    wait_int(1, n); chk("os_latency", 32'(n), 32'd3);
    access(0, TMR_CTRL, 0, rd); chk("os_ctrl", rd, 32'hE);
    access(0, TMR_CNT, 0, rd);  chk("os_cnt", rd, 32'd0);
    access(1, TMR_CTRL, 32'hE, rd);
    repeat (6) step(0, 0, 2'd0, 32'd0);
    chk("os_no_repend", {31'd0, int_o}, 32'd0);

    // Wrap: COUNT passes FFFF_FFFF -> 0 without PEND
    access(1, TMR_CMP, 32'd5, rd);
    access(1, TMR_CNT, 32'hFFFF_FFFE, rd);
    access(1, TMR_CTRL, 32'hB, rd);
    wait_int(1, n); chk("wrap_latency", 32'(n), 32'd8);

    // Collision: COUNT write on the match tick wins, no PEND
    access(1, TMR_CTRL, 32'h0, rd);
    access(1, TMR_PRE, 32'd1, rd);
    access(1, TMR_CMP, 32'd3, rd);
    access(1, TMR_CNT, 32'd3, rd);
    access(1, TMR_CTRL, 32'h9, rd);
    access(1, TMR_CNT, 32'd7, rd);
    access(0, TMR_CNT, 0, rd);  chk("col_cnt", rd, 32'd7);
    access(0, TMR_CTRL, 0, rd); chk("col_nopend", rd, 32'h1);

    // Collision: W1C on the match edge, set wins
    access(1, TMR_CTRL, 32'h0, rd);
    access(1, TMR_CNT, 32'd3, rd);
    access(1, TMR_CTRL, 32'hB, rd);
    chk("setwin_pre", {31'd0, int_o}, 32'd0);
    access(1, TMR_CTRL, 32'hB, rd);
    chk("setwin_int", {31'd0, int_o}, 32'd1);
    access(1, TMR_CTRL, 32'h8, rd);

    // Handshake: cyc held for 5 cycles
    step(1, 0, TMR_CNT, 0); chk("hs1", {31'd0, o_wb_ack}, 32'd1);
    step(1, 0, TMR_CNT, 0); chk("hs2", {31'd0, o_wb_ack}, 32'd0);
    step(1, 0, TMR_CNT, 0); chk("hs3", {31'd0, o_wb_ack}, 32'd1);
    step(1, 0, TMR_CNT, 0); chk("hs4", {31'd0, o_wb_ack}, 32'd0);
    step(1, 0, TMR_CNT, 0);
    step(0, 0, TMR_CNT, 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int k = 0; k < 200; k++) begin
      ra  = 2'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      case (ra)
        2'd0:    rdat = 32'($urandom_range(0, 15));
        2'd1:    rdat = 32'($urandom_range(0, 3));
        2'd2:    rdat = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 8));
        default: rdat = 32'($urandom_range(0, 8));
      endcase
      access(rwe, ra, rdat, rd);
      repeat ($urandom_range(0, 4)) step(0, 0, 2'd0, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
